// File: rtl/cap_sensor_scanner.sv
// Capacitive sensor scanner: discharges a shared RC drive line, then times the rise of each sense
// input during the charge phase, publishes per-channel cycle counts and debounced touch flags.
// Optional feature: define CAP_SCANNER_BASELINE_EN to make touch detection relative to a
// per-channel baseline captured on the first completed scan after reset.
module cap_sensor_scanner #(
    parameter int unsigned NUM_CH           = 9,
    parameter int unsigned CNT_W            = 32,
    parameter int unsigned MAX_COUNT        = 4095,
    parameter int unsigned DISCHARGE_CYCLES = 256,
    parameter int unsigned THRESHOLD        = 200,
    parameter int unsigned DEBOUNCE         = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    scan_en,
    input  logic [NUM_CH-1:0]       sense_in,
    output logic                    drive_out,
    output logic [NUM_CH*CNT_W-1:0] readings,
    output logic [NUM_CH-1:0]       touched,
    output logic [NUM_CH-1:0]       timeout_flags,
`ifdef CAP_SCANNER_BASELINE_EN
    output logic                    baseline_valid,
`endif
    output logic                    scan_done
);

    localparam int unsigned CW = $clog2(MAX_COUNT + 1);
    localparam int unsigned DW = $clog2(DISCHARGE_CYCLES + 1);
    localparam int unsigned BW = $clog2(DEBOUNCE + 1);

    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_COUNT);
    localparam logic [DW-1:0]  DIS_LAST = DW'(DISCHARGE_CYCLES - 1);
    localparam logic [BW-1:0]  DEB_LAST = BW'(DEBOUNCE - 1);
    localparam logic [CNT_W:0] THR_EXT  = (CNT_W + 1)'(THRESHOLD);

    typedef enum logic [1:0] {StIdle, StDischarge, StCharge, StPublish} state_e;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [DW-1:0]     dis_cnt_q;
    logic [CW-1:0]     cnt_q;
    logic [NUM_CH-1:0] latched_q;
    logic [NUM_CH-1:0] timeout_q;
    logic [CW-1:0]     shadow_q [NUM_CH];
    logic [BW-1:0]     deb_q [NUM_CH];
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] over;
    logic              all_latched;
    logic              at_max;
`ifdef CAP_SCANNER_BASELINE_EN
    logic [CW-1:0]     baseline_q [NUM_CH];
`endif

    // Two-flop synchronizer on the asynchronous sense lines
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sense_in;
            sync2_q <= sync1_q;
        end
    end

    // Charge-phase qualifiers: channels rising this cycle, completion and timeout
    always_comb begin
        rise        = ~latched_q & sync2_q;
        all_latched = &(latched_q | rise);
        at_max      = (cnt_q == CNT_MAX);
    end

    // Touch candidate per channel from the freshly captured shadow values
    always_comb begin
        over = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef CAP_SCANNER_BASELINE_EN
            over[i] = ((CNT_W + 1)'(shadow_q[i]) >= ((CNT_W + 1)'(baseline_q[i]) + THR_EXT));
`else
            over[i] = ((CNT_W + 1)'(shadow_q[i]) >= THR_EXT);
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and decoded outputs
    always_comb begin
        state_d   = state_q;
        drive_out = 1'b0;
        scan_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (scan_en) state_d = StDischarge;
            end
            StDischarge: begin
                if (dis_cnt_q == DIS_LAST) state_d = StCharge;
            end
            StCharge: begin
                drive_out = 1'b1;
                if (all_latched || at_max) state_d = StPublish;
            end
            StPublish: begin
                scan_done = 1'b1;
                state_d   = scan_en ? StDischarge : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Discharge timer; zero whenever not discharging so each entry starts fresh
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dis_cnt_q <= '0;
        end else if (state_q == StDischarge) begin
            dis_cnt_q <= dis_cnt_q + 1'b1;
        end else begin
            dis_cnt_q <= '0;
        end
    end

    // Charge counter and per-channel latch of the rise time
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            latched_q <= '0;
            timeout_q <= '0;
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
        end else if (state_q == StDischarge) begin
            cnt_q     <= '0;
            latched_q <= '0;
            timeout_q <= '0;
        end else if (state_q == StCharge) begin
            if (!at_max) cnt_q <= cnt_q + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rise[i]) begin
                    shadow_q[i]  <= cnt_q;
                    latched_q[i] <= 1'b1;
                end else if (at_max && !latched_q[i]) begin
                    // Never rose within the window: saturate and flag
                    shadow_q[i]  <= CNT_MAX;
                    timeout_q[i] <= 1'b1;
                end
            end
        end
    end

    // Publish readings and run the touch debouncer once per completed scan
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readings      <= '0;
            timeout_flags <= '0;
            touched       <= '0;
            for (int i = 0; i < NUM_CH; i++) deb_q[i] <= '0;
`ifdef CAP_SCANNER_BASELINE_EN
            baseline_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) baseline_q[i] <= '0;
`endif
        end else if (state_q == StPublish) begin
            timeout_flags <= timeout_q;
            for (int i = 0; i < NUM_CH; i++) begin
                readings[i*CNT_W +: CNT_W] <= CNT_W'(shadow_q[i]);
            end
`ifdef CAP_SCANNER_BASELINE_EN
            // First scan only establishes the untouched reference
            if (!baseline_valid) begin
                baseline_valid <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) baseline_q[i] <= shadow_q[i];
            end else
`endif
            begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (over[i] != touched[i]) begin
                        if (deb_q[i] == DEB_LAST) begin
                            touched[i] <= ~touched[i];
                            deb_q[i]   <= '0;
                        end else begin
                            deb_q[i] <= deb_q[i] + 1'b1;
                        end
                    end else begin
                        deb_q[i] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cap_sensor_scanner.sv
// Directed bench for cap_sensor_scanner with the default parameter set.
module tb_cap_sensor_scanner;

    localparam int NUM_CH = 9;
    localparam int CNT_W  = 32;

    logic                    clock;
    logic                    reset;
    logic                    scan_en;
    logic [NUM_CH-1:0]       sense_in;
    logic                    drive_out;
    logic [NUM_CH*CNT_W-1:0] readings;
    logic [NUM_CH-1:0]       touched;
    logic [NUM_CH-1:0]       timeout_flags;
    logic                    scan_done;

    int checks   = 0;
    int failures = 0;

    // Charge cycle at which each raw line rises (-1 = never); reading is that cycle + 2
    int                rise_at [NUM_CH];
    logic [NUM_CH-1:0] pre_high;
    int                drop_at;
    int                charge_len;

    cap_sensor_scanner dut (
        .clock         (clock),
        .reset         (reset),
        .scan_en       (scan_en),
        .sense_in      (sense_in),
        .drive_out     (drive_out),
        .readings      (readings),
        .touched       (touched),
        .timeout_flags (timeout_flags),
        .scan_done     (scan_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [CNT_W-1:0] rd(input int ch);
        return readings[ch*CNT_W +: CNT_W];
    endfunction

    task automatic set_rise(input int v);
        for (int ch = 0; ch < NUM_CH; ch++) rise_at[ch] = v;
    endtask

    // Run one scan from wherever the FSM is; returns one cycle after scan_done
    task automatic do_scan();
        int  n;
        int  c;
        bit  seen;
        sense_in = pre_high;
        n = 0;
        while (drive_out !== 1'b1 && n < 2000) begin
            @(posedge clock); #1; n++;
        end
        checks++;
        if (drive_out !== 1'b1) begin
            failures++;
            $display("FAIL charge_start: drive_out=%b required=1 within 2000 cycles", drive_out);
        end
        c = 0;
        seen = 1'b0;
        charge_len = 0;
        while (!seen && c < 5000) begin
            for (int ch = 0; ch < NUM_CH; ch++) if (rise_at[ch] == c) sense_in[ch] = 1'b1;
            if (drop_at == c) scan_en = 1'b0;
            if (drive_out === 1'b1) charge_len++;
            if (scan_done === 1'b1) seen = 1'b1;
            @(posedge clock); #1; c++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL scan_done_wait: no pulse seen, required within 5000 cycles");
        end
        sense_in = '0;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        reset    = 1'b1;
        scan_en  = 1'b1;
        sense_in = '0;
        pre_high = '0;
        drop_at  = -1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (drive_out !== 1'b0) begin
            failures++; $display("FAIL reset_drive: got %b required 0", drive_out);
        end
        checks++;
        if (readings !== '0) begin
            failures++; $display("FAIL reset_readings: got %h required 0", readings);
        end
        checks++;
        if (touched !== '0 || timeout_flags !== '0) begin
            failures++;
            $display("FAIL reset_flags: touched=%b timeout=%b required 0", touched, timeout_flags);
        end
        checks++;
        if (scan_done !== 1'b0) begin
            failures++; $display("FAIL reset_scan_done: got %b required 0", scan_done);
        end
        reset = 1'b1;
        // One IDLE cycle then 256 discharge cycles: drive rises after the 257th edge
        n = 0;
        bad = 0;
        while (drive_out !== 1'b1 && n < 400) begin
            @(posedge clock); #1; n++;
            if (readings !== '0 || touched !== '0 || timeout_flags !== '0 || scan_done !== 1'b0)
                bad++;
        end
        checks++;
        if (n != 257) begin
            failures++; $display("FAIL discharge_len: drive rose after %0d edges required 257", n);
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL outputs_before_first_scan: %0d nonzero cycles required 0", bad);
        end
    endtask

    task automatic test_readings();
        set_rise(50);
        rise_at[0] = 10;
        rise_at[1] = 10;
        do_scan();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++;
            if (rd(ch) !== ((ch < 2) ? 32'd12 : 32'd52)) begin
                failures++;
                $display("FAIL reading_ch%0d: got %0d required %0d", ch, rd(ch),
                         (ch < 2) ? 12 : 52);
            end
        end
        checks++;
        if (timeout_flags !== '0) begin
            failures++; $display("FAIL readings_timeout: got %b required 0", timeout_flags);
        end
        checks++;
        if (scan_done !== 1'b0) begin
            failures++; $display("FAIL scan_done_width: got %b one cycle later required 0", scan_done);
        end
        checks++;
        if (charge_len != 53) begin
            failures++; $display("FAIL charge_len_normal: got %0d required 53", charge_len);
        end
        checks++;
        if (touched !== '0) begin
            failures++; $display("FAIL readings_touched: got %b required 0", touched);
        end
    endtask

    task automatic test_timeout();
        set_rise(20);
        rise_at[4] = -1;
        do_scan();
        checks++;
        if (rd(4) !== 32'd4095) begin
            failures++; $display("FAIL timeout_reading: got %0d required 4095", rd(4));
        end
        checks++;
        if (timeout_flags !== 9'b0_0001_0000) begin
            failures++; $display("FAIL timeout_flags: got %b required 000010000", timeout_flags);
        end
        checks++;
        if (charge_len != 4096) begin
            failures++; $display("FAIL charge_len_timeout: got %0d required 4096", charge_len);
        end
        checks++;
        if (rd(3) !== 32'd22 || rd(5) !== 32'd22) begin
            failures++;
            $display("FAIL timeout_neighbours: ch3=%0d ch5=%0d required 22", rd(3), rd(5));
        end
    endtask

    task automatic test_debounce();
        int seq [9] = '{298, 298, 298, 98, 98, 298, 98, 98, 98};
        bit exp [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic [NUM_CH-1:0] want;
        for (int k = 0; k < 9; k++) begin
            set_rise(20);
            rise_at[2] = seq[k];
            do_scan();
            want = exp[k] ? 9'b0_0000_0100 : 9'b0;
            checks++;
            if (rd(2) !== 32'(seq[k] + 2)) begin
                failures++; $display("FAIL debounce_reading_%0d: got %0d required %0d", k, rd(2),
                                     seq[k] + 2);
            end
            checks++;
            if (touched !== want) begin
                failures++; $display("FAIL debounce_scan_%0d: touched=%b required %b", k, touched,
                                     want);
            end
        end
    endtask

    task automatic test_scan_en_drop();
        int bad;
        set_rise(30);
        drop_at = 10;
        do_scan();
        drop_at = -1;
        checks++;
        if (rd(0) !== 32'd32 || rd(8) !== 32'd32) begin
            failures++; $display("FAIL drop_readings: ch0=%0d ch8=%0d required 32", rd(0), rd(8));
        end
        bad = 0;
        repeat (400) begin
            @(posedge clock); #1;
            if (drive_out !== 1'b0 || scan_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL drop_idle: %0d active cycles after drop required 0", bad);
        end
        checks++;
        if (rd(0) !== 32'd32) begin
            failures++; $display("FAIL idle_hold: ch0=%0d required 32", rd(0));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        scan_en = 1'b1;
        n = 0;
        while (drive_out !== 1'b1 && n < 2000) begin
            @(posedge clock); #1; n++;
        end
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (drive_out !== 1'b0 || scan_done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ctrl: drive=%b done=%b required 0", drive_out, scan_done);
        end
        checks++;
        if (readings !== '0 || touched !== '0 || timeout_flags !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: readings=%h touched=%b timeout=%b required 0",
                     readings, touched, timeout_flags);
        end
        pre_high = 9'b0_0000_1000;
        sense_in = pre_high;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        n = 0;
        while (drive_out !== 1'b1 && n < 400) begin
            @(posedge clock); #1; n++;
        end
        checks++;
        if (n != 257) begin
            failures++; $display("FAIL midreset_discharge: rose after %0d edges required 257", n);
        end
        set_rise(15);
        rise_at[3] = -1;
        do_scan();
        pre_high = '0;
        checks++;
        if (rd(3) !== 32'd0) begin
            failures++; $display("FAIL already_high: ch3=%0d required 0", rd(3));
        end
        checks++;
        if (rd(0) !== 32'd17 || timeout_flags !== '0) begin
            failures++;
            $display("FAIL post_reset_scan: ch0=%0d timeout=%b required 17/0", rd(0), timeout_flags);
        end
    endtask

    initial begin
        test_reset();
        test_readings();
        test_timeout();
        test_debounce();
        test_scan_en_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cap_sensor_scanner.md
Name: cap_sensor_scanner

Overview:
Parametrised successor to the fixed 9-channel capacitive sensor array. It drives one shared charge line, times how long each of NUM_CH sense inputs takes to rise, and publishes packed per-channel cycle counts for the processor. It adds three things the earlier array does not have: a scan enable, timeout saturation, and per-channel debounced touch flags. It sits beside the LED array in the top level and feeds the processor's sensor-readings bus.

Parameters:
NUM_CH, 9, number of sense channels
CNT_W, 32, width of each reading; readings bus is NUM_CH*CNT_W
MAX_COUNT, 4095, charge-phase timeout in cycles; must be < 2^CNT_W
DISCHARGE_CYCLES, 256, cycles the drive line is held low before each charge phase
THRESHOLD, 200, reading >= THRESHOLD counts as "over" (touched candidate)
DEBOUNCE, 3, consecutive scans required to set or clear a touch flag (>=1)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
scan_en  in  1  1 = scan continuously; 0 = finish current scan, then idle
sense_in  in  NUM_CH  raw sensor lines, asynchronous
drive_out  out  1  shared charge line to the sensor RC network
readings  out  NUM_CH*CNT_W  channel i at bits [i*CNT_W +: CNT_W]
touched  out  NUM_CH  debounced touch flag per channel
timeout_flags  out  NUM_CH  channel hit MAX_COUNT in the last published scan
scan_done  out  1  one-cycle pulse when readings/touched update

Behaviour:
- Reset (reset=0, async): state IDLE; drive_out, readings, touched, timeout_flags, scan_done, all debounce counters and synchronizers = 0.
- sense_in passes through a 2-FF synchronizer per channel. A raw rise sampled at the end of charge cycle k is visible in cycle k+2.
- FSM states: IDLE -> DISCHARGE -> CHARGE -> PUBLISH -> DISCHARGE ...
- IDLE: drive_out=0. Go to DISCHARGE when scan_en=1.
- DISCHARGE: drive_out=0 for exactly DISCHARGE_CYCLES cycles, then go to CHARGE. Clear the latched-mask and cycle counter on exit.
- CHARGE: drive_out=1. Counter = 0 in the first CHARGE cycle and increments each cycle.
  - Each unlatched channel whose synced input is 1 latches the current counter value into a shadow register and sets its latched bit.
  - Several channels rising in the same cycle each latch the same value.
  - A channel already high in the first CHARGE cycle latches 0.
  - Exit when all channels are latched, or when counter == MAX_COUNT. Unlatched channels get MAX_COUNT and their timeout bit set.
- PUBLISH: one cycle.
  - Shadow values -> readings; timeout bits -> timeout_flags; scan_done=1 this cycle only.
  - Debounce, per channel:
    - over = (reading >= THRESHOLD). If over != touched, the counter increments, else it resets to 0.
    - When the counter reaches DEBOUNCE, touched toggles and the counter resets.
    - touched changes in the PUBLISH cycle; it is visible from the next cycle.
  - Next state: DISCHARGE if scan_en=1, else IDLE.
- Deasserting scan_en mid-scan does not abort; the current scan completes and publishes.
- readings and touched hold their values between publishes and while in IDLE.
- Counter width: ceil(log2(MAX_COUNT+1)), zero-extended into CNT_W.
- Scan period when no channel times out = DISCHARGE_CYCLES + (cycles in CHARGE) + 1.
- Reset asserted mid-scan: immediate return to reset values; the partial scan is discarded.

Optional Feature:
Macro CAP_SCANNER_BASELINE_EN.
- Defined: the first completed scan after reset captures per-channel baseline registers; touched stays 0 for that scan. From then on, over = (reading >= baseline + THRESHOLD), computed in CNT_W+1 bits with no wrap. The output baseline_valid (1 bit, reset 0) goes high after capture.
- Undefined: absolute THRESHOLD compare, no baseline registers, no baseline_valid port.

Test Plan:
1. Reset low with scan_en=1, sense_in=0, then release -> drive_out=0 for 256 cycles, then 1; all outputs 0 until the first scan_done.
2. Raw ch0 rises at charge cycle 10, ch1 at cycle 10, others at cycle 50 -> readings ch0=ch1=12, others=52; scan_done pulses once; timeout_flags=0.
3. ch4 held at 0 -> ch4 reading=4095, timeout_flags[4]=1, CHARGE lasts 4096 cycles; other channels are read normally.
4. ch2 reading 300 for 3 consecutive scans -> touched[2]=1 after the 3rd scan_done. Then 100 for 2 scans and 300 for 1 -> touched[2] stays 1. Then 100 for 3 scans -> touched[2]=0.
5. scan_en dropped mid-CHARGE -> scan completes, publishes once, FSM enters IDLE, drive_out=0, readings held.
6. Reset pulsed low mid-CHARGE -> all outputs 0 at once; after release the first scan starts with a full DISCHARGE.
